// File: rtl/ascon_permutation_ctrl.sv
// Round sequencer for the Ascon permutation datapath: walks the round index from the
// mode-dependent start round up to LAST_ROUND, driving the state mux select and load enable.
module ascon_permutation_ctrl #(
   parameter int LAST_ROUND = 11,
   parameter int ROUND_W    = 4
) (
   input  logic               clock_i,
   input  logic               resetb_i,
   input  logic               start_i,
   input  logic [1:0]         mode_i,
   output logic [ROUND_W-1:0] round_o,
   output logic               select_o,
   output logic               en_state_o,
   output logic               busy_o,
   output logic               done_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FIRST = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [ROUND_W-1:0] LAST = ROUND_W'(LAST_ROUND);

   state_t               state_q, state_d;
   logic [ROUND_W-1:0]   count_q, count_d;
   logic [ROUND_W-1:0]   start_round;

   // Shorter permutations skip the leading rounds so every run ends on LAST_ROUND.
   always_comb begin
      case (mode_i)
         2'b01:   start_round = LAST - ROUND_W'(7);
         2'b10:   start_round = LAST - ROUND_W'(5);
         default: start_round = LAST - ROUND_W'(11);
      endcase
   end

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      round_o    = '0;
      select_o   = 1'b0;
      en_state_o = 1'b0;
      busy_o     = 1'b0;
      done_o     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = FIRST;
               count_d = start_round;
            end
         end
         FIRST, RUN: begin
            select_o   = (state_q == FIRST);
            en_state_o = 1'b1;
            busy_o     = 1'b1;
            round_o    = count_q;
            // The final round is loaded at this edge; the counter parks at LAST.
            if (count_q == LAST) begin
               state_d = DONE;
            end else begin
               state_d = RUN;
               count_d = count_q + ROUND_W'(1);
            end
         end
         DONE: begin
            done_o  = 1'b1;
            round_o = LAST;
            state_d = IDLE;
            count_d = '0;
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

endmodule
